// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front end: command encodings and FSM state encoding.
package spi_pkg;

  localparam int CMD_W = 2;

  localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
  localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

  // READ_DATA is split into its three sub-phases so the whole FSM fits one register.
  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_CHK_CMD      = 3'd1,
    ST_WRITE        = 3'd2,
    ST_READ_ADD     = 3'd3,
    ST_RD_SHIFT_IN  = 3'd4,
    ST_RD_WAIT_TX   = 3'd5,
    ST_RD_SHIFT_OUT = 3'd6
  } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises MOSI command words, serialises RAM read data onto MISO.
// Optional embedded assertions are compiled in with `define SPI_SLAVE_SVA_EN.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    SS_n,
  input  logic                    MOSI,
  output logic                    MISO,
  output logic [ADDR_W+CMD_W-1:0] rx_data,
  output logic                    rx_valid,
  input  logic [ADDR_W-1:0]       tx_data,
  input  logic                    tx_valid,
  output spi_state_e              dbg_state_o,
  output logic                    dbg_rd_addr_seen_o
);

  localparam int RX_W = ADDR_W + CMD_W;

  localparam logic [2:0] S_IDLE         = ST_IDLE;
  localparam logic [2:0] S_CHK_CMD      = ST_CHK_CMD;
  localparam logic [2:0] S_WRITE        = ST_WRITE;
  localparam logic [2:0] S_READ_ADD     = ST_READ_ADD;
  localparam logic [2:0] S_RD_SHIFT_IN  = ST_RD_SHIFT_IN;
  localparam logic [2:0] S_RD_WAIT_TX   = ST_RD_WAIT_TX;
  localparam logic [2:0] S_RD_SHIFT_OUT = ST_RD_SHIFT_OUT;

  // Shift-in counts 0..RX_W-1 then parks at RX_W; shift-out counts 1..ADDR_W then parks at ADDR_W+1.
  localparam logic [3:0] RX_LAST = 4'(RX_W - 1);
  localparam logic [3:0] RX_DONE = 4'(RX_W);
  localparam logic [3:0] TX_LAST = 4'(ADDR_W);

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [RX_W-2:0]   rx_sh_q, rx_sh_d;
  logic [RX_W-1:0]   rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [ADDR_W-1:0] tx_sh_q, tx_sh_d;
  logic              miso_q, miso_d;
  logic              seen_q, seen_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_sh_d    = tx_sh_q;
    miso_d     = miso_q;
    seen_d     = seen_q;

    // Deselect wins over everything, including a final data bit in the same cycle.
    if (state_q != S_IDLE && SS_n) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!SS_n) begin
            state_d = S_CHK_CMD;
            cnt_d   = '0;
          end
        end
        S_CHK_CMD: begin
          if (!MOSI)       state_d = S_WRITE;
          else if (seen_q) state_d = S_RD_SHIFT_IN;
          else             state_d = S_READ_ADD;
        end
        S_WRITE, S_READ_ADD, S_RD_SHIFT_IN: begin
          if (cnt_q != RX_DONE) begin
            rx_sh_d = {rx_sh_q[RX_W-3:0], MOSI};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == RX_LAST) begin
              rx_data_d  = {rx_sh_q, MOSI};
              rx_valid_d = 1'b1;
              if (state_q == S_READ_ADD) seen_d = 1'b1;
              if (state_q == S_RD_SHIFT_IN) begin
                state_d = S_RD_WAIT_TX;
                cnt_d   = '0;
              end
            end
          end
        end
        S_RD_WAIT_TX: begin
          if (tx_valid) begin
            miso_d  = tx_data[ADDR_W-1];
            tx_sh_d = {tx_data[ADDR_W-2:0], 1'b0};
            cnt_d   = 4'd1;
            state_d = S_RD_SHIFT_OUT;
          end
        end
        S_RD_SHIFT_OUT: begin
          if (cnt_q == TX_LAST) begin
            miso_d = 1'b0;
            seen_d = 1'b0;
            cnt_d  = cnt_q + 4'd1;
          end else if (cnt_q < TX_LAST) begin
            miso_d  = tx_sh_q[ADDR_W-1];
            tx_sh_d = {tx_sh_q[ADDR_W-2:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_sh_q    <= '0;
      miso_q     <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_sh_q    <= tx_sh_d;
      miso_q     <= miso_d;
      seen_q     <= seen_d;
    end
  end

  assign MISO               = miso_q;
  assign rx_data            = rx_data_q;
  assign rx_valid           = rx_valid_q;
  assign dbg_state_o        = spi_state_e'(state_q);
  assign dbg_rd_addr_seen_o = seen_q;

`ifdef SPI_SLAVE_SVA_EN
  a_rx_valid_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    rx_valid_q |=> !rx_valid_q);
  a_miso_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != S_RD_SHIFT_OUT) |-> !miso_q);
  a_deselect_idle: assert property (@(posedge clk) disable iff (!rst_n)
    SS_n |=> (state_q == S_IDLE));
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomised self-checking bench for spi_slave_if against a frame-level reference model.
module tb_spi_slave_if;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  spi_state_e dbg_state;
  logic       dbg_seen;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];
  bit seen_m = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  spi_slave_if #(.ADDR_W(8)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .SS_n               (SS_n),
    .MOSI               (MOSI),
    .MISO               (MISO),
    .rx_data            (rx_data),
    .rx_valid           (rx_valid),
    .tx_data            (tx_data),
    .tx_valid           (tx_valid),
    .dbg_state_o        (dbg_state),
    .dbg_rd_addr_seen_o (dbg_seen)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // driver
  task automatic drive(input logic ss, input logic mosi, input logic tv, input logic [7:0] td);
    SS_n     = ss;
    MOSI     = mosi;
    tx_valid = tv;
    tx_data  = td;
  endtask

  // Samples the current cycle's outputs at the falling edge, then advances past the next rising edge.
  task automatic sample_cycle(input logic exp_rxv, input logic exp_miso, input bit chk_idle);
    logic [9:0] w;
    @(negedge clk);
    check("rx_valid", 32'(rx_valid), 32'(exp_rxv));
    check("miso", 32'(MISO), 32'(exp_miso));
    if (rx_valid && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check("rx_data", 32'(rx_data), 32'(w));
    end
    if (chk_idle) check("idle_after_ss", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #1;
  endtask

  // One SS_n-bounded frame. Cycle 0 is the first cycle SS_n is low; SS_n stays low for l_low cycles.
  task automatic run_frame(input bit cmd, input logic [9:0] word, input int l_low,
                           input int t_tx, input logic [7:0] tx_byte, input int junk_t);
    int   path;
    bit   rx_ok;
    logic m;
    logic mo;
    logic tv;
    logic [7:0] td;
    // 0: no path chosen, 1: write, 2: read address, 3: read data
    path  = (l_low < 2) ? 0 : (!cmd ? 1 : (seen_m ? 3 : 2));
    rx_ok = (path != 0) && (l_low >= 12);
    if (rx_ok) exp_q.push_back(word);
    for (int c = 0; c < l_low + 2; c++) begin
      if (c == 1)                mo = cmd;
      else if (c >= 2 && c <= 11) mo = word[11-c];
      else                       mo = 1'($urandom_range(0, 1));
      tv = 1'b0;
      td = 8'($urandom);
      if (c == t_tx)        begin tv = 1'b1; td = tx_byte; end
      else if (c == junk_t) tv = 1'b1;
      drive((c < l_low) ? 1'b0 : 1'b1, mo, tv, td);
      m = 1'b0;
      if (path == 3 && c >= t_tx + 1 && c <= t_tx + 8 && l_low >= c)
        m = tx_byte[7 - (c - t_tx - 1)];
      sample_cycle(rx_ok && (c == 12), m, c == l_low + 1);
    end
    if (path == 2 && l_low >= 12)        seen_m = 1'b1;
    if (path == 3 && l_low >= t_tx + 9)  seen_m = 1'b0;
    check("rd_addr_seen", 32'(dbg_seen), 32'(seen_m));
    check("rx_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [9:0] w;
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_seen", 32'(dbg_seen), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed frames from the feature list.
    run_frame(1'b0, 10'h005, 25, 13, 8'h5A, 5);   // write address
    run_frame(1'b0, 10'h1AA, 25, 13, 8'hFF, 7);   // write data
    run_frame(1'b1, 10'h205, 25, 13, 8'hC3, 4);   // read address
    run_frame(1'b1, 10'h300, 25, 13, 8'hAA, 6);   // read data, MISO 10101010
    run_frame(1'b0, 10'h0F0, 8, 13, 8'h00, 3);    // abort after 6 data bits
    run_frame(1'b0, 10'h2C7, 25, 13, 8'h00, 3);   // next full frame decodes
    run_frame(1'b0, 10'h3FF, 11, 13, 8'h00, 3);   // SS_n rises with the 10th bit
    run_frame(1'b1, 10'h111, 25, 12, 8'h81, 9);   // read address, earliest tx_valid
    run_frame(1'b1, 10'h3C0, 25, 12, 8'h81, 9);   // read data, tx_valid already in WAIT_TX entry cycle
    run_frame(1'b1, 10'h201, 25, 13, 8'h00, 2);   // read address
    run_frame(1'b1, 10'h300, 18, 13, 8'hF0, 2);   // read data aborted mid shift-out: flag stays set
    run_frame(1'b1, 10'h300, 25, 15, 8'h0F, 2);   // retried read data completes

    // Randomised frames.
    for (int i = 0; i < 40; i++) begin
      run_frame(1'($urandom_range(0, 1)), 10'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 20)) : int'($urandom_range(25, 27)),
                int'($urandom_range(12, 15)), 8'($urandom), int'($urandom_range(2, 11)));
    end

    // Reset in the middle of shifting out 0xFF.
    if (!seen_m) run_frame(1'b1, 10'h2AB, 25, 13, 8'h00, 5);
    w = 10'h3E5;
    exp_q.push_back(w);
    for (int c = 0; c < 17; c++) begin
      drive(1'b0, (c == 1) ? 1'b1 : ((c >= 2 && c <= 11) ? w[11-c] : 1'b0),
            (c == 12) ? 1'b1 : 1'b0, (c == 12) ? 8'hFF : 8'h00);
      sample_cycle(c == 12, c >= 13, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_miso", 32'(MISO), 32'd0);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("midrst_seen", 32'(dbg_seen), 32'd0);
    seen_m = 1'b0;
    exp_q.delete();
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(1'b0, 10'h155, 25, 13, 8'h00, 4);
    run_frame(1'b1, 10'h2FE, 25, 13, 8'h00, 4);   // must take the read-address path again

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
